daub6_decim_fifo: RTL and testbench
===================================

// Module: daub6_decim_fifo
// PURPOSE
//  Downstream stage of the Daubechies-6 fixed-point filter: qualifies its free-running Q15 output,
//  discards the pipeline/tap-fill transient, decimates by 2 (dyadic DWT step) and buffers kept
//  coefficients in a FIFO with a valid/ready interface toward the next DWT level or the sink.
// PARAMETERS
//  DATA_WIDTH     16  sample width, Q15 signed
//  FIFO_DEPTH     8   FIFO entries; power of 2, >= 2
//  SETTLE_SAMPLES 10  valid samples discarded after enable (5-cycle filter latency + 5 tap fill)
//  KEEP_PHASE     0   decimation phase kept (0 = first post-settle sample, 1 = second)
// PORTS
//  clk        in   1                      clock
//  rst_n      in   1                      reset, asynchronous, active-low
//  en         in   1                      stream enable; rising edge starts a new settle window
//  in_data    in   DATA_WIDTH             filter dout, Q15 signed
//  in_valid   in   1                      in_data qualifier; no backpressure to the filter
//  out_data   out  DATA_WIDTH             FIFO head (show-ahead)
//  out_valid  out  1                      FIFO non-empty
//  out_ready  in   1                      consumer accepts head when out_valid && out_ready
//  level      out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  ovf        out  1                      sticky: a kept sample was dropped because the FIFO was full
//  ovf_clr    in   1                      clears ovf (takes priority over a same-cycle set)
// BEHAVIOUR
//  - Reset: state IDLE, out_data=0, out_valid=0, level=0, ovf=0, counters 0; FIFO contents lost.
//  - FSM IDLE: en=0 ignores input. en=1 -> SETTLE, settle_cnt=0, phase=0.
//  - SETTLE: each in_valid increments settle_cnt; on the SETTLE_SAMPLES-th sample -> RUN (that
//    sample discarded). SETTLE_SAMPLES=0 goes IDLE->RUN directly.
//  - RUN: each in_valid toggles phase; sample with phase==KEEP_PHASE is kept, other dropped silently.
//  - en=0 in SETTLE/RUN -> IDLE next cycle; sample on that cycle ignored; FIFO keeps data and drains.
//  - Write: kept sample written same cycle; out_valid visible next cycle (1-cycle latency).
//  - Full: write allowed if out_ready && out_valid in same cycle (pop frees slot); else sample
//    dropped, ovf set. Empty: pop ignored. Simultaneous push+pop: level unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; level in 0..FIFO_DEPTH.
//  - No arithmetic on data; values pass bit-exact. out_data holds last head value when empty.
// CONFIGURATION
//  DAUB6_DECIM_DROPCNT_EN defined: adds port drop_cnt out 16, count of full-FIFO drops, saturates at
//  16'hFFFF, cleared by ovf_clr and reset. Undefined: port and counter absent; ovf only.
// STRUCTURE
//  - daub6_pkg: state enum (IDLE, SETTLE, RUN), DAUB6_FILTER_LATENCY=5, DAUB6_TAPS=6, Q15 width.
//  - Sub-module daub6_sync_fifo: show-ahead synchronous FIFO (push, pop, full, empty, level).
//  - Top holds FSM, settle counter, phase bit, ovf/drop logic.
// TESTING
//  - Reset mid-stream with 3 entries queued -> level=0, out_valid=0 next cycle, state IDLE.
//  - en=1, in_valid every cycle, in_data=1..30 -> outputs 11,13,15,...,29 (KEEP_PHASE=0).
//  - Same stimulus, KEEP_PHASE=1 -> outputs 12,14,...,30; in_valid gaps do not shift phase.
//  - out_ready=0, 20 kept samples, DEPTH=8 -> level=8, ovf=1, drop_cnt=12 (macro on).
//  - Full FIFO, out_ready=1 while kept sample arrives -> sample written, level stays 8, ovf unchanged.
//  - en dropped after 4 kept samples, out_ready=1 -> 4 samples drain, then out_valid=0; en re-rise
//    discards next 10 samples again.

Source files
------------

// File: rtl/daub6_pkg.sv
// ---------------------------------------------------------------------------
// daub6_pkg
// Shared definitions for the Daubechies-6 decimation / buffering stage.
//   daub6_state_e        : stream qualification FSM states (IDLE, SETTLE, RUN)
//   DAUB6_FILTER_LATENCY : pipeline latency of the upstream filter, in samples
//   DAUB6_TAPS           : filter length; TAPS-1 samples are needed to fill taps
//   DAUB6_Q15_WIDTH      : Q15 signed sample width
//   DAUB6_SETTLE_DEFAULT : transient length discarded after enable
//   daub6_sat_inc16      : saturating 16-bit increment
// ---------------------------------------------------------------------------
package daub6_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } daub6_state_e;

  localparam int DAUB6_FILTER_LATENCY = 5;
  localparam int DAUB6_TAPS           = 6;
  localparam int DAUB6_Q15_WIDTH      = 16;

  // Pipeline latency plus the tap fill (TAPS-1) gives the full transient.
  localparam int DAUB6_SETTLE_DEFAULT = DAUB6_FILTER_LATENCY + DAUB6_TAPS - 1;

  // Saturating increment used by diagnostic counters.
  function automatic logic [15:0] daub6_sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage : daub6_pkg

// File: rtl/daub6_sync_fifo.sv
// ---------------------------------------------------------------------------
// daub6_sync_fifo
// Show-ahead synchronous FIFO. The head entry is visible on head_o whenever
// the FIFO is non-empty; when empty, head_o holds the last head presented
// (zero after reset).
// A push while full is accepted only if a pop happens in the same cycle.
// A pop while empty is ignored.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : write request, push_data_i written at the clock edge
//   push_data_i   : write data
//   pop_i         : read request, advances past the current head
//   head_o        : show-ahead head data
//   full_o        : level == DEPTH
//   empty_o       : level == 0
//   level_o       : occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module daub6_sync_fifo
  import daub6_pkg::*;
#(
  parameter  int DATA_WIDTH = DAUB6_Q15_WIDTH,
  parameter  int DEPTH      = 8,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [LVL_W-1:0]      level_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign level_o = count_q;

  // A pop frees the head slot in the same cycle, so a full FIFO may still
  // accept a push when it is also being popped.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Remember the head while non-empty so the output holds when drained.
  assign last_d = empty_o ? last_q : mem_q[rd_ptr_q];
  assign head_o = last_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : daub6_sync_fifo

// File: rtl/daub6_decim_fifo.sv
// ---------------------------------------------------------------------------
// daub6_decim_fifo
// Downstream stage of the Daubechies-6 Q15 filter. Qualifies the free-running
// filter output, discards the transient after each enable rising edge,
// decimates by 2 and buffers the kept coefficients in a show-ahead FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stream enable; rising edge starts a new settle window
//   in_data    : filter output sample, Q15 signed (passed bit-exact)
//   in_valid   : in_data qualifier, no backpressure toward the filter
//   out_data   : FIFO head (show-ahead), holds last head when empty
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts head when out_valid && out_ready
//   level      : FIFO occupancy 0..FIFO_DEPTH
//   ovf        : sticky flag, a kept sample was dropped on a full FIFO
//   ovf_clr    : clears ovf (wins over a same-cycle set)
//   drop_cnt   : saturating count of full-FIFO drops (only with
//                DAUB6_DECIM_DROPCNT_EN defined), cleared by ovf_clr
// Optional feature macro: DAUB6_DECIM_DROPCNT_EN
// ---------------------------------------------------------------------------
module daub6_decim_fifo
  import daub6_pkg::*;
#(
  parameter  int DATA_WIDTH     = DAUB6_Q15_WIDTH,
  parameter  int FIFO_DEPTH     = 8,
  parameter  int SETTLE_SAMPLES = DAUB6_SETTLE_DEFAULT,
  parameter  int KEEP_PHASE     = 0,
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LVL_W-1:0]      level,
  output logic                  ovf,
  input  logic                  ovf_clr
`ifdef DAUB6_DECIM_DROPCNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  // The settle counter only needs to reach SETTLE_SAMPLES-1.
  localparam int CNT_W = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam logic KEEP_BIT = 1'(KEEP_PHASE);

  daub6_state_e     state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             phase_q, phase_d;
  logic             ovf_q, ovf_d;
  logic             keep;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  // Qualification FSM. Any cycle with en low in SETTLE/RUN returns to IDLE
  // and ignores that cycle's sample; the IDLE cycle that sees en high only
  // arms the settle window.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    phase_d      = phase_q;
    keep         = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          settle_cnt_d = '0;
          phase_d      = 1'b0;
          state_d      = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
        end
      end
      SETTLE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (in_valid) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = RUN;
            phase_d = 1'b0;
          end else begin
            settle_cnt_d = settle_cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (in_valid) begin
          keep    = (phase_q == KEEP_BIT);
          phase_d = ~phase_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      phase_q      <= phase_d;
    end
  end

  daub6_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (keep),
    .push_data_i (in_data),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign out_valid = !fifo_empty;

  // A kept sample is lost only if the FIFO is full and no pop frees a slot.
  assign drop = keep && fifo_full && !(out_ready && out_valid);

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

`ifdef DAUB6_DECIM_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      drop_cnt_d = '0;
    end else if (drop) begin
      drop_cnt_d = daub6_sat_inc16(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule : daub6_decim_fifo

// File: tb/tb_daub6_decim_fifo.sv
// ---------------------------------------------------------------------------
// tb_daub6_decim_fifo
// Two instances share all inputs: dut0 keeps phase 0, dut1 keeps phase 1.
// Expected outputs come from a queue-based reference model that counts
// samples since the enable window opened and applies the decimation rule
// arithmetically. Optional macro: DAUB6_DECIM_DROPCNT_EN.
// ---------------------------------------------------------------------------
module tb_daub6_decim_fifo;

  localparam int W      = 16;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 10;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] inData = '0;
  logic         inValid = 1'b0;
  logic         outReady = 1'b0;
  logic         ovfClr = 1'b0;

  logic [W-1:0]     outData0, outData1;
  logic             outValid0, outValid1;
  logic [LVL_W-1:0] level0, level1;
  logic             ovf0, ovf1;
`ifdef DAUB6_DECIM_DROPCNT_EN
  logic [15:0]      dropCnt0, dropCnt1;
`endif

  daub6_decim_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .SETTLE_SAMPLES(SETTLE), .KEEP_PHASE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(inData), .in_valid(inValid),
    .out_data(outData0), .out_valid(outValid0), .out_ready(outReady),
    .level(level0), .ovf(ovf0), .ovf_clr(ovfClr)
`ifdef DAUB6_DECIM_DROPCNT_EN
    , .drop_cnt(dropCnt0)
`endif
  );

  daub6_decim_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .SETTLE_SAMPLES(SETTLE), .KEEP_PHASE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(inData), .in_valid(inValid),
    .out_data(outData1), .out_valid(outValid1), .out_ready(outReady),
    .level(level1), .ovf(ovf1), .ovf_clr(ovfClr)
`ifdef DAUB6_DECIM_DROPCNT_EN
    , .drop_cnt(dropCnt1)
`endif
  );

  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail = 0;

  // Reference model state
  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];
  int           nSince = 0;
  bit           enPrev = 1'b0;
  bit           mOvf[2];
  int           mDrop[2];
  logic [W-1:0] mLast[2];

  bit           recording = 1'b0;
  logic [W-1:0] rec0[$];
  logic [W-1:0] rec1[$];

  function automatic int qSize(int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [W-1:0] qFront(int d);
    return (d == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qPush(int d, logic [W-1:0] v);
    if (d == 0) mq0.push_back(v);
    else mq1.push_back(v);
  endtask

  task automatic qPop(int d);
    if (d == 0) void'(mq0.pop_front());
    else void'(mq1.pop_front());
  endtask

  task automatic checkEq(string tag, logic [31:0] obs, logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq0.delete();
    mq1.delete();
    nSince = 0;
    enPrev = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mOvf[d]  = 1'b0;
      mDrop[d] = 0;
      mLast[d] = '0;
    end
  endtask

  // A sample belongs to the stream only once en has been high for the
  // previous cycle too; the index counts from the start of the window.
  task automatic modelStep();
    bit counted;
    int idx;
    bit pop;
    bit keep;
    bit dropEv;
    counted = en && enPrev && inValid;
    idx = nSince;
    if (counted) nSince++;
    if (!en) nSince = 0;
    for (int d = 0; d < 2; d++) begin
      pop = outReady && (qSize(d) > 0);
      keep = counted && (idx >= SETTLE) && (((idx - SETTLE) % 2) == d);
      dropEv = 1'b0;
      if (pop) qPop(d);
      if (keep) begin
        if (qSize(d) < DEPTH) qPush(d, inData);
        else dropEv = 1'b1;
      end
      if (ovfClr) begin
        mOvf[d]  = 1'b0;
        mDrop[d] = 0;
      end else if (dropEv) begin
        mOvf[d] = 1'b1;
        if (mDrop[d] < 16'hFFFF) mDrop[d]++;
      end
    end
    enPrev = en;
  endtask

  task automatic checkOutput();
    logic [W-1:0] expData;
    bit expValid;
    for (int d = 0; d < 2; d++) begin
      expValid = qSize(d) > 0;
      expData  = expValid ? qFront(d) : mLast[d];
      if (expValid) mLast[d] = expData;
      checkEq($sformatf("dut%0d.out_valid", d), (d == 0) ? 32'(outValid0) : 32'(outValid1), 32'(expValid));
      checkEq($sformatf("dut%0d.level", d), (d == 0) ? 32'(level0) : 32'(level1), 32'(qSize(d)));
      checkEq($sformatf("dut%0d.out_data", d), (d == 0) ? 32'(outData0) : 32'(outData1), 32'(expData));
      checkEq($sformatf("dut%0d.ovf", d), (d == 0) ? 32'(ovf0) : 32'(ovf1), 32'(mOvf[d]));
`ifdef DAUB6_DECIM_DROPCNT_EN
      checkEq($sformatf("dut%0d.drop_cnt", d), (d == 0) ? 32'(dropCnt0) : 32'(dropCnt1), 32'(mDrop[d]));
`endif
    end
  endtask

  // Called at a negedge: check current outputs, drive the next inputs,
  // advance the model and move on to the following negedge.
  task automatic applyStimulus(bit e, bit v, logic [W-1:0] dat, bit r, bit c);
    checkOutput();
    if (recording && r) begin
      if (outValid0) rec0.push_back(outData0);
      if (outValid1) rec1.push_back(outData1);
    end
    en = e;
    inValid = v;
    inData = dat;
    outReady = r;
    ovfClr = c;
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runRamp(int gapEvery);
    rec0.delete();
    rec1.delete();
    recording = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      if (gapEvery > 0 && (i % gapEvery) == 0) applyStimulus(1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, W'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    recording = 1'b0;
    checkEq($sformatf("ramp%0d.count0", gapEvery), 32'(rec0.size()), 32'd10);
    checkEq($sformatf("ramp%0d.count1", gapEvery), 32'(rec1.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < rec0.size()) checkEq($sformatf("ramp%0d.keep0[%0d]", gapEvery, k), 32'(rec0[k]), 32'(11 + 2 * k));
      if (k < rec1.size()) checkEq($sformatf("ramp%0d.keep1[%0d]", gapEvery, k), 32'(rec1[k]), 32'(12 + 2 * k));
    end
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkEq("reset.level0", 32'(level0), 32'd0);
    checkEq("reset.out_valid0", 32'(outValid0), 32'd0);
    checkEq("reset.out_data0", 32'(outData0), 32'd0);
    checkEq("reset.ovf0", 32'(ovf0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 1..30 without gaps, then with in_valid gaps
    runRamp(0);
    runRamp(3);

    // Overflow: 10 discarded + 40 samples -> 20 kept per instance
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b1, W'(100 + i), 1'b0, 1'b0);
    checkEq("ovf.level0", 32'(level0), 32'(DEPTH));
    checkEq("ovf.flag0", 32'(ovf0), 32'd1);
`ifdef DAUB6_DECIM_DROPCNT_EN
    checkEq("ovf.drop_cnt0", 32'(dropCnt0), 32'd12);
`endif
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    // Sample index 50 is kept by dut0 while it pops: written, level stays full
    applyStimulus(1'b1, 1'b1, 16'h7ABC, 1'b1, 1'b0);
    checkEq("fullpop.level0", 32'(level0), 32'(DEPTH));
    checkEq("fullpop.ovf0", 32'(ovf0), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // en dropped after 4 kept samples: queue drains, then out_valid falls
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b1, W'(200 + i), 1'b0, 1'b0);
    checkEq("endrop.level0", 32'(level0), 32'd4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, W'(300 + i), 1'b1, 1'b0);
    checkEq("endrop.out_valid0", 32'(outValid0), 32'd0);
    checkEq("endrop.hold0", 32'(outData0), 32'(200 + 16));
    // Re-rise: the next 10 samples are discarded again
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, W'(400 + i), 1'b1, 1'b0);
    checkEq("rerise.level0", 32'(level0), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h9ABC, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hDEF0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
    checkEq("rerise.head0", 32'(outData0), 32'h1234);

    // Asynchronous reset mid-stream with 3 entries queued
    checkEq("midreset.pre_level0", 32'(level0), 32'd3);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkEq("midreset.level0", 32'(level0), 32'd0);
    checkEq("midreset.out_valid0", 32'(outValid0), 32'd0);
    checkEq("midreset.level1", 32'(level1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // en already high: first cycle is the IDLE arming cycle, then settle
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, W'(500 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(99) >= 4), ($urandom_range(99) < 70), W'($urandom),
                    ($urandom_range(99) < 55), ($urandom_range(99) < 3));
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule : tb_daub6_decim_fifo
